// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini multi-cycle CPU: opcodes, FSM states and
// instruction field positions.
package mini_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_BEQZ = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_OUT  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int INSTR_W = 16;
    localparam int FIELD_W = 4;
    localparam int IMM_W   = 8;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/mini_cpu_alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR with zero and carry (borrow on SUB).
module mini_cpu_alu
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Operation select; the extra top bit of diff_s is the unsigned borrow.
    always_comb begin
        result = {DATA_W{1'b0}};
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum_s[DATA_W-1:0];
                carry  = sum_s[DATA_W];
            end
            OP_SUB: begin
                result = diff_s[DATA_W-1:0];
                carry  = diff_s[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: begin
                result = {DATA_W{1'b0}};
                carry  = 1'b0;
            end
        endcase
        zero = (result == {DATA_W{1'b0}});
    end

endmodule

// File: rtl/mini_cpu_mc.sv
// Multi-cycle CPU core: 4-state instruction sequencer, program counter,
// register file and instruction memory around the mini_cpu_alu datapath.
module mini_cpu_mc
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NREG       = 8,
    parameter int IMEM_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [15:0]                   prog_data,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic                          halted,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          zero_flag,
    output logic                          carry_flag
);

    localparam int RA_W = $clog2(NREG);
    localparam int PC_W = $clog2(IMEM_DEPTH);

    logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];
    logic [DATA_W-1:0]  rf_q   [NREG];

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, rd_val_q, rd_val_d;
    logic [DATA_W-1:0]  res_q, res_d, out_data_q, out_data_d;
    logic               alu_zero_q, alu_zero_d, alu_carry_q, alu_carry_d;
    logic               take_q, take_d, halted_q, halted_d, out_valid_q, out_valid_d;
    logic               zero_flag_q, zero_flag_d, carry_flag_q, carry_flag_d;

    logic [3:0]         opcode_s;
    logic [RA_W-1:0]    rd_s, rs_s, rt_s;
    logic [IMM_W-1:0]   imm_s;
    logic [PC_W-1:0]    target_s;
    logic [DATA_W-1:0]  alu_result_s;
    logic               alu_zero_s, alu_carry_s, rf_we_s;
    logic               unused_ir_s;

    assign opcode_s    = ir_q[OPC_LSB +: FIELD_W];
    assign rd_s        = ir_q[RD_LSB +: RA_W];
    assign rs_s        = ir_q[RS_LSB +: RA_W];
    assign rt_s        = ir_q[RT_LSB +: RA_W];
    assign imm_s       = ir_q[IMM_LSB +: IMM_W];
    assign target_s    = imm_s[PC_W-1:0];
    assign unused_ir_s = ^ir_q;

    mini_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (opcode_s),
        .a      (op_a_q),
        .b      (op_b_q),
        .result (alu_result_s),
        .zero   (alu_zero_s),
        .carry  (alu_carry_s)
    );

    // Instruction sequencing and datapath next-state; r0 always reads as zero.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rd_val_d     = rd_val_q;
        res_d        = res_q;
        alu_zero_d   = alu_zero_q;
        alu_carry_d  = alu_carry_q;
        take_d       = take_q;
        zero_flag_d  = zero_flag_q;
        carry_flag_d = carry_flag_q;
        halted_d     = halted_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        rf_we_s      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = imem_q[pc_q];
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_a_d   = (rs_s == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : rf_q[rs_s];
                op_b_d   = (rt_s == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : rf_q[rt_s];
                rd_val_d = (rd_s == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : rf_q[rd_s];
                state_d  = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                res_d       = (opcode_s == OP_LDI) ? DATA_W'(imm_s) : alu_result_s;
                alu_zero_d  = alu_zero_s;
                alu_carry_d = alu_carry_s;
                take_d      = (opcode_s == OP_JMP) ||
                              ((opcode_s == OP_BEQZ) && (rd_val_q == {DATA_W{1'b0}}));
                // Registered here so the pulse lines up with the WRITEBACK cycle.
                out_valid_d = (opcode_s == OP_OUT);
                out_data_d  = (opcode_s == OP_OUT) ? rd_val_q : out_data_q;
                state_d     = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                rf_we_s      = (is_alu_op(opcode_s) || (opcode_s == OP_LDI)) &&
                               (rd_s != {RA_W{1'b0}}) && !reset;
                zero_flag_d  = is_alu_op(opcode_s) ? alu_zero_q  : zero_flag_q;
                carry_flag_d = is_alu_op(opcode_s) ? alu_carry_q : carry_flag_q;
                if (opcode_s == OP_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = take_q ? target_s : pc_q + PC_W'(1);
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= {PC_W{1'b0}};
            ir_q         <= {INSTR_W{1'b0}};
            op_a_q       <= {DATA_W{1'b0}};
            op_b_q       <= {DATA_W{1'b0}};
            rd_val_q     <= {DATA_W{1'b0}};
            res_q        <= {DATA_W{1'b0}};
            alu_zero_q   <= 1'b0;
            alu_carry_q  <= 1'b0;
            take_q       <= 1'b0;
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
            halted_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rd_val_q     <= rd_val_d;
            res_q        <= res_d;
            alu_zero_q   <= alu_zero_d;
            alu_carry_q  <= alu_carry_d;
            take_q       <= take_d;
            zero_flag_q  <= zero_flag_d;
            carry_flag_q <= carry_flag_d;
            halted_q     <= halted_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // Register file write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (rf_we_s) begin
            rf_q[rd_s] <= res_q;
        end
    end

    // Program load port, active in every state including reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            imem_q[prog_addr] <= prog_data;
        end
    end

    assign pc         = pc_q;
    assign halted     = halted_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign zero_flag  = zero_flag_q;
    assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_mini_cpu_mc.sv
// Directed programs for mini_cpu_mc; expected OUT results go into a scoreboard
// queue that a negedge monitor drains whenever out_valid is seen.
module tb_mini_cpu_mc;

    typedef struct packed {
        logic [7:0] data;
        logic       z;
        logic       c;
    } exp_t;

    logic        clk;
    logic        reset, prog_we;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  pc;
    logic        halted, out_valid, zero_flag, carry_flag;
    logic [7:0]  out_data;

    logic        s_reset, s_prog_we;
    logic [1:0]  s_prog_addr;
    logic [15:0] s_prog_data;
    logic [1:0]  s_pc;
    logic        s_halted, s_out_valid, s_zero, s_carry;
    logic [7:0]  s_out_data;

    exp_t        sb_q [$];
    logic [15:0] prog_q [$];
    int          checks = 0;
    int          errors = 0;

    mini_cpu_mc dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .pc(pc), .halted(halted), .out_valid(out_valid),
        .out_data(out_data), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    mini_cpu_mc #(.DATA_W(8), .NREG(8), .IMEM_DEPTH(4)) dut_small (
        .clk(clk), .reset(s_reset), .prog_we(s_prog_we), .prog_addr(s_prog_addr),
        .prog_data(s_prog_data), .pc(s_pc), .halted(s_halted), .out_valid(s_out_valid),
        .out_data(s_out_data), .zero_flag(s_zero), .carry_flag(s_carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every OUT pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            exp_t act;
            exp_t e;
            act = '{data: out_data, z: zero_flag, c: carry_flag};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected actual data=%0d z=%0b c=%0b required=no pulse",
                         out_data, zero_flag, carry_flag);
            end else begin
                e = sb_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL out_pulse actual data=%0d z=%0b c=%0b required data=%0d z=%0b c=%0b",
                             act.data, act.z, act.c, e.data, e.z, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] d, input logic z, input logic c);
        sb_q.push_back('{data: d, z: z, c: c});
    endtask

    task automatic load_word(input logic [4:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
    endtask

    task automatic load_prog();
        reset = 1'b1;
        for (int i = 0; i < prog_q.size(); i++) begin
            load_word(5'(i), prog_q[i]);
        end
    endtask

    task automatic load_small(input logic [1:0] a, input logic [15:0] d);
        s_prog_we   = 1'b1;
        s_prog_addr = a;
        s_prog_data = d;
        @(posedge clk);
        #1;
        s_prog_we   = 1'b0;
    endtask

    task automatic run_until_halted(input string name, input int exp_cyc);
        int n = 0;
        logic done = 1'b0;
        while (!done && n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (halted === 1'b1) done = 1'b1;
        end
        check({name, "_halted"}, 32'(done), 32'd1);
        if (exp_cyc >= 0) check({name, "_cycles"}, n, exp_cyc);
        check({name, "_pending"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = 5'd0; prog_data = 16'h0000;
        s_reset = 1'b1; s_prog_we = 1'b0; s_prog_addr = 2'd0; s_prog_data = 16'h0000;

        // 5+3 = 8, HALT reached 20 cycles after release at pc 4
        prog_q = {16'h1105, 16'h1203, 16'h2312, 16'h9300, 16'hF000};
        load_prog();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_zero", 32'(zero_flag), 32'd0);
        check("rst_carry", 32'(carry_flag), 32'd0);
        expect_out(8'd8, 1'b0, 1'b0);
        reset = 1'b0;
        run_until_halted("prog1", 20);
        check("prog1_pc", 32'(pc), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        check("prog1_hold_pc", 32'(pc), 32'd4);
        check("prog1_hold_halted", 32'(halted), 32'd1);

        // 200+100 wraps to 44 with carry
        prog_q = {16'h11C8, 16'h1264, 16'h2312, 16'h9300, 16'hF000};
        load_prog();
        expect_out(8'd44, 1'b0, 1'b1);
        reset = 1'b0;
        run_until_halted("add_carry", 20);
        check("add_carry_cf", 32'(carry_flag), 32'd1);

        // SUB zero/borrow, then logic ops clearing carry
        prog_q = {16'h1107, 16'h3311, 16'h9300, 16'h1102, 16'h1205, 16'h3312, 16'h9300,
                  16'h5512, 16'h9500, 16'h4612, 16'h9600, 16'h6712, 16'h9700, 16'hF000};
        load_prog();
        expect_out(8'd0, 1'b1, 1'b0);
        expect_out(8'd253, 1'b0, 1'b1);
        expect_out(8'd7, 1'b0, 1'b0);
        expect_out(8'd0, 1'b1, 1'b0);
        expect_out(8'd7, 1'b0, 1'b0);
        reset = 1'b0;
        run_until_halted("sub_logic", -1);

        // BEQZ taken, OUT, JMP back to HALT at address 2
        prog_q = {16'h1100, 16'h7103, 16'hF000, 16'h9100, 16'h8002};
        load_prog();
        expect_out(8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        run_until_halted("loop", 20);
        check("loop_pc", 32'(pc), 32'd2);

        // r0 writes discarded but flags still update
        prog_q = {16'h1109, 16'h3011, 16'h9000, 16'h1005, 16'h9000, 16'hF000};
        load_prog();
        expect_out(8'd0, 1'b1, 1'b0);
        expect_out(8'd0, 1'b1, 1'b0);
        reset = 1'b0;
        run_until_halted("r0", 24);

        // Overwrite address 0 during its FETCH: the old LDI must execute
        prog_q = {16'h115A, 16'h9100, 16'hF000};
        load_prog();
        expect_out(8'h5A, 1'b0, 1'b0);
        reset = 1'b0;
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 16'hF000;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        run_until_halted("rbw", -1);
        check("rbw_pc", 32'(pc), 32'd2);

        // Reset during EXECUTE of ADD r3: r3 keeps 7, flags stay clear
        prog_q = {16'h11C8, 16'h1264, 16'h1307, 16'h2312, 16'h9300, 16'hF000};
        load_prog();
        reset = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        load_word(5'd0, 16'h9300);
        load_word(5'd1, 16'hF000);
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_carry", 32'(carry_flag), 32'd0);
        expect_out(8'd7, 1'b0, 1'b0);
        reset = 1'b0;
        run_until_halted("midrst", 8);
        check("midrst_halt_pc", 32'(pc), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("haltrst_halted", 32'(halted), 32'd0);
        check("haltrst_pc", 32'(pc), 32'd0);

        // IMEM_DEPTH = 4: NOP sweep wraps the pc, then JMP 9 lands on 1
        for (int a = 0; a < 4; a++) load_small(2'(a), 16'h0000);
        s_reset = 1'b0;
        @(posedge clk);
        #1;
        for (int j = 0; j < 6; j++) begin
            check($sformatf("small_pc_%0d", j), 32'(s_pc), 32'(j % 4));
            repeat (4) @(posedge clk);
            #1;
        end
        check("small_out_valid", 32'(s_out_valid), 32'd0);
        check("small_halted", 32'(s_halted), 32'd0);
        check("small_flags", {30'd0, s_zero, s_carry}, 32'd0);
        check("small_out_data", 32'(s_out_data), 32'd0);
        s_reset = 1'b1;
        load_small(2'd0, 16'h8009);
        s_reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("small_jmp_pc", 32'(s_pc), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("small_after_jmp_pc", 32'(s_pc), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
